// File: rtl/leap_frame_parser.sv
// Leap link frame parser: finds SYNC_BYTE-aligned 5-byte frames, verifies the XOR checksum,
// publishes good frames and counts checksum/timeout errors.
module leap_frame_parser #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 8680,
  parameter int         TO_W           = 14
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  output logic [39:0] frame,
  output logic [7:0]  pos_x,
  output logic [7:0]  pos_y,
  output logic [7:0]  pos_z,
  output logic        frame_valid,
  output logic        err_checksum,
  output logic        err_timeout,
  output logic [15:0] frame_count,
  output logic [7:0]  error_count,
  output logic        hunting
);

  // Handshake: in_valid is a one-cycle strobe with no ready/backpressure; every
  // cycle with in_valid high delivers exactly one byte, which is always consumed.

  typedef enum logic [0:0] {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } state_e;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_e          state_q;
  logic [2:0]      idx_q;
  logic [31:0]     buf_q;
  logic [7:0]      xor_q;
  logic [TO_W-1:0] to_q;
  logic [39:0]     frame_q;
  logic            frame_valid_q;
  logic            err_checksum_q;
  logic            err_timeout_q;
  logic [15:0]     frame_count_q;
  logic [7:0]      error_count_q;
  logic            hunting_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= HUNT;
      idx_q          <= 3'd0;
      buf_q          <= 32'd0;
      xor_q          <= 8'd0;
      to_q           <= '0;
      frame_q        <= 40'd0;
      frame_valid_q  <= 1'b0;
      err_checksum_q <= 1'b0;
      err_timeout_q  <= 1'b0;
      frame_count_q  <= 16'd0;
      error_count_q  <= 8'd0;
      hunting_q      <= 1'b1;
    end else begin
      frame_valid_q  <= 1'b0;
      err_checksum_q <= 1'b0;
      err_timeout_q  <= 1'b0;
      case (state_q)
        HUNT: begin
          to_q <= '0;
          if (in_valid && (in_byte == SYNC_BYTE)) begin
            buf_q[7:0] <= in_byte;
            xor_q      <= in_byte;
            idx_q      <= 3'd1;
            state_q    <= COLLECT;
            hunting_q  <= 1'b0;
          end
        end
        COLLECT: begin
          // An accepted byte takes priority over a timeout expiring in the same cycle.
          if (in_valid) begin
            to_q  <= '0;
            idx_q <= idx_q + 3'd1;
            case (idx_q)
              3'd1: begin buf_q[15:8]  <= in_byte; xor_q <= xor_q ^ in_byte; end
              3'd2: begin buf_q[23:16] <= in_byte; xor_q <= xor_q ^ in_byte; end
              3'd3: begin buf_q[31:24] <= in_byte; xor_q <= xor_q ^ in_byte; end
              default: begin
                if (in_byte == xor_q) begin
                  frame_q       <= {in_byte, buf_q};
                  frame_valid_q <= 1'b1;
                  frame_count_q <= frame_count_q + 16'd1;
                end else begin
                  err_checksum_q <= 1'b1;
                  if (error_count_q != 8'hFF) error_count_q <= error_count_q + 8'd1;
                end
                idx_q     <= 3'd0;
                state_q   <= HUNT;
                hunting_q <= 1'b1;
              end
            endcase
          end else if (to_q == TO_LAST) begin
            err_timeout_q <= 1'b1;
            if (error_count_q != 8'hFF) error_count_q <= error_count_q + 8'd1;
            to_q      <= '0;
            idx_q     <= 3'd0;
            state_q   <= HUNT;
            hunting_q <= 1'b1;
          end else begin
            to_q <= to_q + 1'b1;
          end
        end
        default: begin
          state_q   <= HUNT;
          hunting_q <= 1'b1;
        end
      endcase
    end
  end

  assign frame        = frame_q;
  assign pos_x        = frame_q[15:8];
  assign pos_y        = frame_q[23:16];
  assign pos_z        = frame_q[31:24];
  assign frame_valid  = frame_valid_q;
  assign err_checksum = err_checksum_q;
  assign err_timeout  = err_timeout_q;
  assign frame_count  = frame_count_q;
  assign error_count  = error_count_q;
  assign hunting      = hunting_q;

endmodule

// File: tb/tb_leap_frame_parser.sv
// Directed bench for leap_frame_parser: clean/bad frames, resync, timeout edge,
// mid-frame reset, back-to-back frames and error counter saturation.
module tb_leap_frame_parser;

  localparam int T = 8680;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic [39:0] frame;
  logic [7:0]  pos_x;
  logic [7:0]  pos_y;
  logic [7:0]  pos_z;
  logic        frame_valid;
  logic        err_checksum;
  logic        err_timeout;
  logic [15:0] frame_count;
  logic [7:0]  error_count;
  logic        hunting;

  int total = 0;
  int bad   = 0;

  int fv_cnt = 0;
  int ck_cnt = 0;
  int to_cnt = 0;
  int cyc    = 0;
  int fv_cyc_q[$];

  leap_frame_parser dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_byte      (in_byte),
    .in_valid     (in_valid),
    .frame        (frame),
    .pos_x        (pos_x),
    .pos_y        (pos_y),
    .pos_z        (pos_z),
    .frame_valid  (frame_valid),
    .err_checksum (err_checksum),
    .err_timeout  (err_timeout),
    .frame_count  (frame_count),
    .error_count  (error_count),
    .hunting      (hunting)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse monitor: counts pulses and checks they are mutually exclusive
  always @(posedge clk) begin
    cyc++;
    if (rst_n) begin
      if (frame_valid) begin
        fv_cnt++;
        fv_cyc_q.push_back(cyc);
      end
      if (err_checksum) ck_cnt++;
      if (err_timeout) to_cnt++;
      if (frame_valid || err_checksum || err_timeout)
        chk("pulse_onehot", 40'({frame_valid, err_checksum, err_timeout} & ({frame_valid, err_checksum, err_timeout} - 3'd1)), 40'd0);
    end
  end

  // Driver tasks
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    in_byte  = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b0, b1, b2, b3, b4);
    send(b0); send(b1); send(b2); send(b3); send(b4);
  endtask

  task automatic stream(input logic [7:0] b0, b1, b2, b3, b4);
    logic [7:0] v [5];
    v = '{b0, b1, b2, b3, b4};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_byte  = v[i];
      in_valid = 1'b1;
    end
  endtask

  int fv0;
  int ck0;
  int to0;

  initial begin
    rst_n    = 1'b0;
    in_byte  = 8'h00;
    in_valid = 1'b0;
    idle(3);
    chk("rst_frame", frame, 40'd0);
    chk("rst_frame_count", 40'(frame_count), 40'd0);
    chk("rst_error_count", 40'(error_count), 40'd0);
    chk("rst_hunting", 40'(hunting), 40'd1);
    chk("rst_pulses", 40'({frame_valid, err_checksum, err_timeout}), 40'd0);
    rst_n = 1'b1;
    idle(2);

    // Clean frame, 4340 cycles between strobes
    send(8'hA5); idle(4338);
    send(8'h12); idle(4338);
    send(8'h34); idle(4338);
    send(8'h56); idle(4338);
    send(8'hD5);
    chk("clean_fv", 40'(frame_valid), 40'd1);
    chk("clean_frame", frame, 40'hD5_56_34_12_A5);
    chk("clean_pos", 40'({pos_x, pos_y, pos_z}), 40'h12_34_56);
    chk("clean_count", 40'(frame_count), 40'd1);
    chk("clean_err_cnt", 40'(error_count), 40'd0);
    idle(1);
    chk("clean_fv_drop", 40'(frame_valid), 40'd0);

    // Bad checksum
    send_frame(8'hA5, 8'h12, 8'h34, 8'h56, 8'hD4);
    chk("bad_ck_pulse", 40'(err_checksum), 40'd1);
    chk("bad_ck_fv", 40'(frame_valid), 40'd0);
    chk("bad_ck_frame_hold", frame, 40'hD5_56_34_12_A5);
    chk("bad_ck_err_cnt", 40'(error_count), 40'd1);
    chk("bad_ck_hunting", 40'(hunting), 40'd1);
    idle(1);
    chk("bad_ck_drop", 40'(err_checksum), 40'd0);
    send_frame(8'hA5, 8'h12, 8'h34, 8'h56, 8'hD5);
    chk("after_bad_fv", 40'(frame_valid), 40'd1);
    chk("after_bad_count", 40'(frame_count), 40'd2);

    // Resync through garbage
    idle(2);
    fv0 = fv_cnt; ck0 = ck_cnt; to0 = to_cnt;
    send(8'h00); send(8'hFF); send(8'h5A);
    idle(2);
    chk("garbage_hunting", 40'(hunting), 40'd1);
    chk("garbage_no_pulse", 40'((fv_cnt - fv0) + (ck_cnt - ck0) + (to_cnt - to0)), 40'd0);
    send_frame(8'hA5, 8'h12, 8'h34, 8'h56, 8'hD5);
    idle(2);
    chk("resync_one_fv", 40'(fv_cnt - fv0), 40'd1);
    chk("resync_count", 40'(frame_count), 40'd3);

    // Sync byte as payload
    send_frame(8'hA5, 8'hA5, 8'h00, 8'h00, 8'h00);
    chk("sync_payload_fv", 40'(frame_valid), 40'd1);
    chk("sync_payload_frame", frame, 40'h00_00_00_A5_A5);
    chk("sync_payload_pos_x", 40'(pos_x), 40'hA5);
    chk("sync_payload_count", 40'(frame_count), 40'd4);

    // Timeout: pulse exactly T cycles after the last strobe
    idle(2);
    send(8'hA5); send(8'h12);
    idle(T - 1);
    chk("to_early", 40'(err_timeout), 40'd0);
    chk("to_early_hunting", 40'(hunting), 40'd0);
    idle(1);
    chk("to_pulse", 40'(err_timeout), 40'd1);
    chk("to_err_cnt", 40'(error_count), 40'd2);
    chk("to_hunting", 40'(hunting), 40'd1);
    idle(1);
    chk("to_drop", 40'(err_timeout), 40'd0);
    send_frame(8'hA5, 8'h12, 8'h34, 8'h56, 8'hD5);
    chk("after_to_fv", 40'(frame_valid), 40'd1);
    chk("after_to_count", 40'(frame_count), 40'd5);

    // Byte lands on the exact timeout cycle and wins
    idle(2);
    to0 = to_cnt;
    send(8'hA5); send(8'h12);
    idle(T - 2);
    send(8'h34);
    chk("to_race_no_pulse", 40'(err_timeout), 40'd0);
    chk("to_race_collect", 40'(hunting), 40'd0);
    send(8'h56); send(8'hD5);
    chk("to_race_fv", 40'(frame_valid), 40'd1);
    chk("to_race_count", 40'(frame_count), 40'd6);
    idle(2);
    chk("to_race_no_to", 40'(to_cnt - to0), 40'd0);

    // Reset mid-frame
    send(8'hA5); send(8'h12);
    @(negedge clk);
    rst_n = 1'b0;
    idle(1);
    chk("mid_rst_frame_count", 40'(frame_count), 40'd0);
    chk("mid_rst_error_count", 40'(error_count), 40'd0);
    chk("mid_rst_frame", frame, 40'd0);
    chk("mid_rst_hunting", 40'(hunting), 40'd1);
    idle(2);
    rst_n = 1'b1;
    fv0 = fv_cnt; ck0 = ck_cnt;
    send(8'h34); send(8'h56); send(8'hD5);
    chk("mid_rst_discard_fv", 40'(frame_valid), 40'd0);
    chk("mid_rst_discard_hunt", 40'(hunting), 40'd1);
    send_frame(8'hA5, 8'h12, 8'h34, 8'h56, 8'hD5);
    chk("mid_rst_fv", 40'(frame_valid), 40'd1);
    chk("mid_rst_count", 40'(frame_count), 40'd1);
    idle(2);
    chk("mid_rst_one_fv", 40'(fv_cnt - fv0), 40'd1);
    chk("mid_rst_no_ck", 40'(ck_cnt - ck0), 40'd0);

    // Back-to-back: ten consecutive strobes
    fv_cyc_q.delete();
    stream(8'hA5, 8'h12, 8'h34, 8'h56, 8'hD5);
    stream(8'hA5, 8'h01, 8'h02, 8'h03, 8'hA5);
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b_fv", 40'(frame_valid), 40'd1);
    chk("b2b_frame", frame, 40'hA5_03_02_01_A5);
    chk("b2b_count", 40'(frame_count), 40'd3);
    idle(2);
    chk("b2b_two_fv", 40'(fv_cyc_q.size()), 40'd2);
    if (fv_cyc_q.size() == 2)
      chk("b2b_gap", 40'(fv_cyc_q[1] - fv_cyc_q[0]), 40'd5);

    // Error counter saturation
    for (int i = 0; i < 300; i++) begin
      stream(8'hA5, 8'h12, 8'h34, 8'h56, 8'hD4);
      if (i == 253) begin
        @(negedge clk);
        in_valid = 1'b0;
        chk("sat_254", 40'(error_count), 40'hFE);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    idle(1);
    chk("sat_ff", 40'(error_count), 40'hFF);
    chk("sat_frame_hold", frame, 40'hA5_03_02_01_A5);
    chk("sat_frame_count", 40'(frame_count), 40'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
